// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous single-port memory between two requesters:
//   port 0 : multi-cycle CPU memory interface (fetch and load/store)
//   port 1 : loader / debug master
// Each access runs through an IDLE -> ISSUE -> WAIT -> DONE sequence. The
// memory read latency (MEM_LAT, 1..15) is counted in WAIT.
//
// Arbitration is round-robin by default. When the macro
// MEM_ARB_CPU_PRIO_EN is defined, port 0 has fixed priority instead.
//
// Ports:
//   clk                    system clock, all state on posedge
//   rst                    asynchronous active-low reset
//   req0/req1              access request, held until the matching ack
//   we0/we1                1 = write, 0 = read
//   addr0/addr1            word address
//   wdata0/wdata1          write data
//   ack0/ack1              one-cycle completion pulse
//   rdata0/rdata1          read data, valid with ack, held until the next read
//   mem_en/mem_we          memory strobe / write enable (ISSUE cycle only)
//   mem_addr/mem_wdata     latched address / write data of the current access
//   mem_rdata              memory read data
//   grant                  port owning the current or last access
//   busy                   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       we_q;
    logic       pick;

    // Winner of the current IDLE cycle; only used when at least one req is high.
`ifdef MEM_ARB_CPU_PRIO_EN
    always_comb begin
        pick = 1'b1;
        if (req0) begin
            pick = 1'b0;
        end
    end
`else
    // Under contention the port that did not own the last access wins.
    // grant resets to 1 so port 0 wins the very first contention.
    always_comb begin
        pick = 1'b1;
        if (req0 && req1) begin
            pick = ~grant;
        end else if (req0) begin
            pick = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            grant     <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant     <= pick;
                        mem_addr  <= pick ? addr1  : addr0;
                        mem_wdata <= pick ? wdata1 : wdata0;
                        we_q      <= pick ? we1    : we0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= LAT;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Last wait cycle: mem_rdata is valid now, MEM_LAT
                    // cycles after the mem_en cycle.
                    if (cnt <= 4'd1) begin
                        if (!we_q) begin
                            if (grant) begin
                                rdata1 <= mem_rdata;
                            end else begin
                                rdata0 <= mem_rdata;
                            end
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the state register, so an async reset
    // drops them in the same instant it clears the state.
    assign mem_en = (state == ISSUE);
    assign mem_we = (state == ISSUE) && we_q;
    assign ack0   = (state == DONE) && !grant;
    assign ack1   = (state == DONE) && grant;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances: u_dut with MEM_LAT=1
// (backed by a 256-word memory model) and u_dut3 with MEM_LAT=3 (backed by a
// 3-stage read pipeline returning {16'hC0DE, addr[15:0]}). Memory models
// return a poison word in every cycle that is not the valid read slot.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          grant, busy;

    logic          l3_req0;
    logic [AW-1:0] l3_addr0;
    logic          l3_ack0, l3_ack1;
    logic [DW-1:0] l3_rdata0, l3_rdata1;
    logic          l3_mem_en, l3_mem_we;
    logic [AW-1:0] l3_mem_addr;
    logic [DW-1:0] l3_mem_wdata;
    logic [DW-1:0] l3_mem_rdata;
    logic          l3_grant, l3_busy;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(l3_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(l3_addr0), .addr1('0), .wdata0('0), .wdata1('0),
        .ack0(l3_ack0), .ack1(l3_ack1), .rdata0(l3_rdata0), .rdata1(l3_rdata1),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata),
        .grant(l3_grant), .busy(l3_busy)
    );

    // Latency-1 memory: data read in the mem_en cycle appears in the next one.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : POISON;
    end

    // Latency-3 memory: three-stage pipeline.
    logic [DW-1:0] l3_pipe [0:2];
    always @(posedge clk) begin
        l3_pipe[0] <= (l3_mem_en && !l3_mem_we) ? {16'hC0DE, l3_mem_addr[15:0]} : POISON;
        l3_pipe[1] <= l3_pipe[0];
        l3_pipe[2] <= l3_pipe[1];
    end
    assign l3_mem_rdata = l3_pipe[2];

    // Ack monitor.
    int ack0_cnt = 0;
    int both_cnt = 0;
    always @(negedge clk) begin
        if (ack0) ack0_cnt++;
        if (ack0 && ack1) both_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        l3_req0 = 1'b0; l3_addr0 = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int ack_port [0:3];
    int ack_cyc  [0:3];
    int n_acks;
    int ack_at;
    int busy_n;
    int en_n;
    int a0_n;
    int a0_snap;
    int exp_port [0:3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h30] = 32'h55AA_33CC;

        // ---------------- reset values ----------------
        rst = 1'b0;
        idle_inputs();
        step(2);
        check_output("rst_ack0", ack0, 0);
        check_output("rst_ack1", ack1, 0);
        check_output("rst_mem_en", mem_en, 0);
        check_output("rst_mem_we", mem_we, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_grant", grant, 1);
        check_output("rst_rdata0", rdata0, 0);
        check_output("rst_rdata1", rdata1, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        step(1);

        // ---------------- single read, port 0 ----------------
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        step(1);
        check_output("rd_t1_mem_en", mem_en, 1);
        check_output("rd_t1_mem_we", mem_we, 0);
        check_output("rd_t1_mem_addr", mem_addr, 32'h10);
        check_output("rd_t1_grant", grant, 0);
        check_output("rd_t1_busy", busy, 1);
        step(1);
        check_output("rd_t2_mem_en", mem_en, 0);
        check_output("rd_t2_ack0", ack0, 0);
        step(1);
        check_output("rd_t3_ack0", ack0, 1);
        check_output("rd_t3_ack1", ack1, 0);
        check_output("rd_t3_rdata0", rdata0, 32'hDEAD_BEEF);
        req0 = 1'b0;
        step(1);
        check_output("rd_t4_ack0", ack0, 0);
        check_output("rd_t4_busy", busy, 0);

        // ---------------- write then readback, port 1 ----------------
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
        step(1);
        check_output("wr_t1_mem_en", mem_en, 1);
        check_output("wr_t1_mem_we", mem_we, 1);
        check_output("wr_t1_mem_addr", mem_addr, 32'h20);
        check_output("wr_t1_mem_wdata", mem_wdata, 32'h1234_5678);
        check_output("wr_t1_grant", grant, 1);
        step(1);
        check_output("wr_t2_mem_we", mem_we, 0);
        step(1);
        check_output("wr_t3_ack1", ack1, 1);
        check_output("wr_t3_rdata1", rdata1, 0);
        we1 = 1'b0;
        step(1);
        check_output("wr_t4_busy", busy, 0);
        step(1);
        check_output("rb_t1_mem_en", mem_en, 1);
        check_output("rb_t1_mem_we", mem_we, 0);
        step(2);
        check_output("rb_t3_ack1", ack1, 1);
        check_output("rb_t3_rdata1", rdata1, 32'h1234_5678);
        req1 = 1'b0;
        step(1);

        // ---------------- contention from reset ----------------
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        step(2);
        rst = 1'b1;
        n_acks = 0;
        for (int cyc = 1; cyc <= 40 && n_acks < 4; cyc++) begin
            step(1);
            if (ack0 || ack1) begin
                ack_port[n_acks] = ack1 ? 1 : 0;
                ack_cyc[n_acks]  = cyc;
                n_acks++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check_output("cont_n_acks", 64'(n_acks), 4);
`ifdef MEM_ARB_CPU_PRIO_EN
        exp_port[0] = 0; exp_port[1] = 0; exp_port[2] = 0; exp_port[3] = 0;
`else
        exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0; exp_port[3] = 1;
`endif
        if (n_acks == 4) begin
            check_output("cont_first_cyc", 64'(ack_cyc[0]), 3);
            for (int i = 0; i < 4; i++) begin
                check_output($sformatf("cont_port%0d", i), 64'(ack_port[i]), 64'(exp_port[i]));
            end
            for (int i = 1; i < 4; i++) begin
                check_output($sformatf("cont_gap%0d", i), 64'(ack_cyc[i] - ack_cyc[i-1]), 4);
            end
        end
        check_output("cont_rdata0", rdata0, 32'hDEAD_BEEF);
`ifndef MEM_ARB_CPU_PRIO_EN
        check_output("cont_rdata1", rdata1, 32'h1234_5678);
`endif
        step(2);

        // ---------------- MEM_LAT = 3 ----------------
        l3_req0 = 1'b1; l3_addr0 = 32'h44;
        ack_at = 0; busy_n = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (l3_busy) busy_n++;
            if (l3_ack0) begin
                ack_at  = k;
                l3_req0 = 1'b0;
            end
        end
        l3_req0 = 1'b0;
        check_output("lat3_ack_cyc", 64'(ack_at), 5);
        check_output("lat3_busy_cycles", 64'(busy_n), 5);
        check_output("lat3_rdata0", l3_rdata0, 32'hC0DE_0044);

        // ---------------- reset mid-WAIT ----------------
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        step(1);
        check_output("rw_issue_mem_en", mem_en, 1);
        step(1);
        check_output("rw_wait_busy", busy, 1);
        #1 rst = 1'b0;
        #1;
        check_output("rw_rst_busy", busy, 0);
        check_output("rw_rst_mem_en", mem_en, 0);
        check_output("rw_rst_ack0", ack0, 0);
        check_output("rw_rst_grant", grant, 1);
        check_output("rw_rst_mem_addr", mem_addr, 0);
        check_output("rw_rst_rdata0", rdata0, 0);
        step(2);
        check_output("rw_hold_ack0", ack0, 0);
        rst = 1'b1;
        ack_at = 0;
        for (int k = 1; k <= 10 && ack_at == 0; k++) begin
            step(1);
            if (ack0) ack_at = k;
        end
        req0 = 1'b0;
        check_output("rw_after_ack_cyc", 64'(ack_at), 3);
        check_output("rw_after_rdata0", rdata0, 32'hDEAD_BEEF);
        step(2);

        // ---------------- req dropped in ISSUE ----------------
        a0_snap = ack0_cnt;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
        step(1);
        check_output("drop_issue_mem_en", mem_en, 1);
        req0 = 1'b0;
        ack_at = 0; en_n = 0; a0_n = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (mem_en) en_n++;
            if (ack0) begin
                a0_n++;
                ack_at = k;
            end
        end
        check_output("drop_ack_cyc", 64'(ack_at), 2);
        check_output("drop_ack_pulses", 64'(a0_n), 1);
        check_output("drop_extra_mem_en", 64'(en_n), 0);
        check_output("drop_busy", busy, 0);
        check_output("drop_rdata0", rdata0, 32'h55AA_33CC);
        check_output("drop_ack0_total", 64'(ack0_cnt - a0_snap), 1);

        check_output("never_both_acks", 64'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
